flag_unit: RTL

FLAG_UNIT -- requirements
Module: flag_unit

---
 rtl/flag_unit_pkg.sv | 49 ++++
 rtl/flag_stack.sv | 66 ++++++
 rtl/flag_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/flag_unit_pkg.sv
// Shared processor definitions: ALU opcodes, flag bit indices, jump condition codes.
// FLAG_UNIT_OVERFLOW_EN enables the V flag, its write enable and the V jump condition.
package flag_unit_pkg;

    localparam int unsigned NUM_FLAGS = 4;

    // Bit positions inside the {V,N,C,Z} flag vector
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 3;

`ifdef FLAG_UNIT_OVERFLOW_EN
    localparam bit                   OVF_EN    = 1'b1;
    localparam int unsigned          STK_W     = 4;
    localparam logic [NUM_FLAGS-1:0] FLAG_MASK = 4'b1111;
`else
    localparam bit                   OVF_EN    = 1'b0;
    localparam int unsigned          STK_W     = 3;
    localparam logic [NUM_FLAGS-1:0] FLAG_MASK = 4'b0111;
`endif

    typedef enum logic [2:0] {
        COND_ALWAYS = 3'd0,
        COND_Z      = 3'd1,
        COND_N      = 3'd2,
        COND_C      = 3'd3,
        COND_V      = 3'd4
    } cond_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SHL = 4'd5,
        ALU_SHR = 4'd6,
        ALU_CMP = 4'd7
    } alu_op_e;

    typedef struct packed {
        logic v;
        logic n;
        logic c;
        logic z;
    } flags_t;

endpackage

// File: rtl/flag_stack.sv
// LIFO of saved flag words for nested interrupts; push and pop together leave it unchanged.
module flag_stack #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign push_ok = push & ~pop & ~full;
    assign pop_ok  = pop & ~push & ~empty;
    assign level   = level_q;

    always_comb begin
        level_d = level_q;
        if (push_ok) begin
            level_d = level_q + LW'(1);
        end else if (pop_ok) begin
            level_d = level_q - LW'(1);
        end
    end

    // Top-of-stack read: entry at index level-1, zero when empty
    always_comb begin
        dout = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (level_q == LW'(i + 1)) begin
                dout = mem_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (push_ok && (level_q == LW'(i))) begin
                    mem_q[i] <= din;
                end
            end
        end
    end

endmodule

// File: rtl/flag_unit.sv
// Processor status flags: ALU update, carry force, conditional-jump test-and-clear, interrupt save/restore.
// V flag support is built only when FLAG_UNIT_OVERFLOW_EN is defined.
module flag_unit
    import flag_unit_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               alu_z,
    input  logic                               alu_c,
    input  logic                               alu_v,
    input  logic                               alu_n,
    input  logic [3:0]                         flag_we,
    input  logic                               setc,
    input  logic                               clrc,
    input  logic                               jmp_valid,
    input  logic [2:0]                         jmp_cond,
    input  logic                               int_save,
    input  logic                               rti_restore,
    output logic [3:0]                         flags,
    output logic                               take,
    output logic                               stk_err,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stk_level
);

    localparam int unsigned LW = $clog2(STACK_DEPTH + 1);

    logic [NUM_FLAGS-1:0] flags_q;
    logic [NUM_FLAGS-1:0] flags_d;
    logic                 take_q;
    logic                 take_d;
    logic                 err_q;
    logic                 err_d;

    logic [NUM_FLAGS-1:0] alu_flags;
    logic [NUM_FLAGS-1:0] we_eff;
    logic [NUM_FLAGS-1:0] clr_mask;
    logic                 cond_true;
    logic                 jump_taken;

    logic                 stk_push;
    logic                 stk_pop;
    logic [STK_W-1:0]     stk_dout;
    logic [LW-1:0]        stk_lvl;
    logic                 stk_full;
    logic                 stk_empty;

    assign alu_flags = {alu_v, alu_n, alu_c, alu_z};
    assign we_eff    = flag_we & FLAG_MASK;

    // Condition test uses registered flags only; no forwarding from alu_* inputs
    always_comb begin
        cond_true = 1'b0;
        clr_mask  = '0;
        case (cond_e'(jmp_cond))
            COND_ALWAYS: cond_true = 1'b1;
            COND_Z: begin
                cond_true        = flags_q[FLAG_Z];
                clr_mask[FLAG_Z] = 1'b1;
            end
            COND_N: begin
                cond_true        = flags_q[FLAG_N];
                clr_mask[FLAG_N] = 1'b1;
            end
            COND_C: begin
                cond_true        = flags_q[FLAG_C];
                clr_mask[FLAG_C] = 1'b1;
            end
            COND_V: begin
                cond_true        = OVF_EN & flags_q[FLAG_V];
                clr_mask[FLAG_V] = 1'b1;
            end
            default: cond_true = 1'b0;
        endcase
        jump_taken = jmp_valid & cond_true;
    end

    // Sources applied lowest priority first so later assignments win
    always_comb begin
        flags_d  = flags_q;
        take_d   = jump_taken;
        err_d    = 1'b0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;

        for (int unsigned i = 0; i < NUM_FLAGS; i++) begin
            if (we_eff[i]) begin
                flags_d[i] = alu_flags[i];
            end
        end

        if (setc) begin
            flags_d[FLAG_C] = 1'b1;
        end else if (clrc) begin
            flags_d[FLAG_C] = 1'b0;
        end

        if (jump_taken) begin
            flags_d = flags_d & ~clr_mask;
        end

        // Save with restore is a swap: stack untouched, flags take the top entry
        if (int_save && rti_restore) begin
            if (!stk_empty) begin
                flags_d = NUM_FLAGS'(stk_dout);
            end
        end else if (rti_restore) begin
            if (stk_empty) begin
                err_d = 1'b1;
            end else begin
                stk_pop = 1'b1;
                flags_d = NUM_FLAGS'(stk_dout);
            end
        end else if (int_save) begin
            if (stk_full) begin
                err_d = 1'b1;
            end else begin
                stk_push = 1'b1;
            end
        end

        flags_d = flags_d & FLAG_MASK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            take_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            take_q  <= take_d;
            err_q   <= err_d;
        end
    end

    flag_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (STK_W)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (flags_q[STK_W-1:0]),
        .dout  (stk_dout),
        .level (stk_lvl),
        .full  (stk_full),
        .empty (stk_empty)
    );

    assign flags     = flags_q;
    assign take      = take_q;
    assign stk_err   = err_q;
    assign stk_level = stk_lvl;

endmodule
